// File: rtl/uart_rx_fifo_if.sv
// Receive-side stream and status bundle for uart_rx_fifo.
// The receiver drives the data/status side (master); the consumer drives
// rx_ready and err_clr (slave).
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [CNT_W-1:0] fifo_count;
    logic             frame_err;
    logic             overrun;
    logic             err_clr;
    logic             irq;

    modport master (
        output rx_data, rx_valid, fifo_count, frame_err, overrun, irq,
        input  rx_ready, err_clr
    );

    modport slave (
        input  rx_data, rx_valid, fifo_count, frame_err, overrun, irq,
        output rx_ready, err_clr
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// Framing and overrun errors are sticky until err_clr; irq follows rx_valid.
// The serial path never waits on the consumer: a byte that finds the FIFO
// full (with no pop in the same cycle) is dropped and flagged.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] clk_div,
    uart_rx_fifo_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // ---------------- input synchroniser ----------------
    logic sync1_q;
    logic rx_s_q;

    // Two-flop synchroniser; both stages reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // ---------------- receiver FSM ----------------
    state_t           state_q;
    logic [DIV_W-1:0] baud_cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;

    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] half_m1;
    logic [DIV_W-1:0] full_m1;
    logic             stop_tick;
    logic             push_req;
    logic             frame_evt;

    assign div_clamped = (clk_div < DIV_W'(4)) ? DIV_W'(4) : clk_div;
    assign half_m1     = (div_q >> 1) - DIV_W'(1);
    assign full_m1     = div_q - DIV_W'(1);
    assign stop_tick   = (state_q == STOP) && (baud_cnt_q == full_m1);
    assign push_req    = stop_tick && rx_s_q;
    assign frame_evt   = stop_tick && !rx_s_q;

    // Frame sequencer: start-bit check at half a bit, then data and stop
    // sampled every full bit; the divider is frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            div_q      <= DIV_W'(4);
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                        div_q   <= div_clamped;
                    end
                end
                START: begin
                    if (baud_cnt_q == half_m1) begin
                        baud_cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt_q == full_m1) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (stop_tick) begin
                        baud_cnt_q <= '0;
                        state_q    <= rx_s_q ? IDLE : WAIT_HIGH;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + DIV_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    baud_cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    baud_cnt_q <= '0;
                end
            endcase
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       rx_data_q;

    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             overrun_evt;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_d;
    logic [7:0]       head_d;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign pop         = !empty && bus.rx_ready;
    assign push        = push_req && (!full || pop);
    assign overrun_evt = push_req && full && !pop;
    assign rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    // The new head bypasses storage when it is the byte being written now.
    assign head_d      = (push && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage array; contents only matter while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Pointers, occupancy and the registered head byte, which holds its
    // last value once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rx_data_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (count_d != '0) begin
                rx_data_q <= head_d;
            end
        end
    end

    // ---------------- sticky error flags ----------------
    logic frame_err_q;
    logic overrun_q;

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (frame_evt) begin
                frame_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (overrun_evt) begin
                overrun_q <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = !empty;
    assign bus.fifo_count = count_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.irq        = !empty;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: drives 8N1 frames on rx
// with hand-computed expected bytes, counts and flags.
module tb_uart_rx_fifo;
    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] clk_div;
    int          bitCyc;
    int          total;
    int          bad;

    uart_rx_fifo_if #(.DEPTH(4)) bus ();

    uart_rx_fifo #(.DEPTH(4), .DIV_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .clk_div (clk_div),
        .bus     (bus)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame, one negedge per cycle. Optional hooks: a one-cycle
    // rx_ready pulse at readyCyc, a push-latency check around latCyc, and a
    // clk_div change at divCyc.
    task automatic applyStimulus(input logic [7:0] b, input int stopLow,
                                 input int readyCyc, input int latCyc,
                                 input int divCyc, input logic [15:0] newDiv);
        int idx;
        for (int cyc = 0; cyc < (10 + stopLow) * bitCyc; cyc++) begin
            @(negedge clk);
            idx = cyc / bitCyc;
            if (idx == 0)                rx = 1'b0;
            else if (idx <= 8)           rx = b[idx-1];
            else if (idx < 9 + stopLow)  rx = 1'b0;
            else                         rx = 1'b1;
            if (readyCyc >= 0) bus.rx_ready = (cyc == readyCyc);
            if (divCyc >= 0 && cyc == divCyc) clk_div = newDiv;
            if (latCyc >= 0 && cyc == latCyc)     checkOutput("valid_before_push", {31'd0, bus.rx_valid}, 32'd0);
            if (latCyc >= 0 && cyc == latCyc + 1) checkOutput("valid_after_push",  {31'd0, bus.rx_valid}, 32'd1);
        end
        rx = 1'b1;
        if (readyCyc >= 0) bus.rx_ready = 1'b0;
    endtask

    task automatic popCheck(input string tag, input logic [7:0] expected);
        checkOutput({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd1);
        checkOutput(tag, {24'd0, bus.rx_data}, {24'd0, expected});
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic pulseErrClr();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        rx           = 1'b1;
        clk_div      = 16'd8;
        bitCyc       = 8;
        bus.rx_ready = 1'b0;
        bus.err_clr  = 1'b0;

        // Reset values.
        idle(3);
        checkOutput("rst_data",   {24'd0, bus.rx_data}, 32'h0);
        checkOutput("rst_valid",  {31'd0, bus.rx_valid}, 32'd0);
        checkOutput("rst_count",  {29'd0, bus.fifo_count}, 32'd0);
        checkOutput("rst_ferr",   {31'd0, bus.frame_err}, 32'd0);
        checkOutput("rst_ovr",    {31'd0, bus.overrun}, 32'd0);
        checkOutput("rst_irq",    {31'd0, bus.irq}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // 1: single byte, push latency, pop, data held after drain.
        applyStimulus(8'h3D, 0, -1, 78, -1, 16'd0);
        checkOutput("t1_data",  {24'd0, bus.rx_data}, 32'h3D);
        checkOutput("t1_count", {29'd0, bus.fifo_count}, 32'd1);
        checkOutput("t1_irq",   {31'd0, bus.irq}, 32'd1);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        checkOutput("t1_valid_after_pop", {31'd0, bus.rx_valid}, 32'd0);
        checkOutput("t1_count_after_pop", {29'd0, bus.fifo_count}, 32'd0);
        checkOutput("t1_data_held",       {24'd0, bus.rx_data}, 32'h3D);
        checkOutput("t1_irq_after_pop",   {31'd0, bus.irq}, 32'd0);
        idle(4);

        // 2: five bytes into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 0, -1, -1, -1, 16'd0);
            idle(2);
        end
        checkOutput("t2_count",   {29'd0, bus.fifo_count}, 32'd4);
        checkOutput("t2_overrun", {31'd0, bus.overrun}, 32'd1);
        checkOutput("t2_ferr",    {31'd0, bus.frame_err}, 32'd0);
        popCheck("t2_pop1", 8'h01);
        popCheck("t2_pop2", 8'h02);
        popCheck("t2_pop3", 8'h03);
        popCheck("t2_pop4", 8'h04);
        checkOutput("t2_count_empty", {29'd0, bus.fifo_count}, 32'd0);
        pulseErrClr();
        checkOutput("t2_overrun_clr", {31'd0, bus.overrun}, 32'd0);
        idle(4);

        // 3: stop bit held low for three bit times, then a good frame.
        applyStimulus(8'hA5, 3, -1, -1, -1, 16'd0);
        checkOutput("t3_count_after_bad", {29'd0, bus.fifo_count}, 32'd0);
        idle(4);
        applyStimulus(8'h5A, 0, -1, -1, -1, 16'd0);
        idle(2);
        checkOutput("t3_ferr",  {31'd0, bus.frame_err}, 32'd1);
        checkOutput("t3_ovr",   {31'd0, bus.overrun}, 32'd0);
        checkOutput("t3_count", {29'd0, bus.fifo_count}, 32'd1);
        popCheck("t3_data", 8'h5A);
        pulseErrClr();
        checkOutput("t3_ferr_clr", {31'd0, bus.frame_err}, 32'd0);
        idle(4);

        // 4: two-clock low glitch on an idle line, then a normal frame.
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(10);
        checkOutput("t4_count", {29'd0, bus.fifo_count}, 32'd0);
        checkOutput("t4_ferr",  {31'd0, bus.frame_err}, 32'd0);
        checkOutput("t4_ovr",   {31'd0, bus.overrun}, 32'd0);
        applyStimulus(8'h96, 0, -1, -1, -1, 16'd0);
        idle(2);
        checkOutput("t4_count_after", {29'd0, bus.fifo_count}, 32'd1);
        popCheck("t4_data", 8'h96);
        idle(4);

        // 5: divider below minimum runs at 4; back-to-back frames; divider
        // change mid-frame ignored.
        clk_div = 16'd2;
        bitCyc  = 4;
        applyStimulus(8'hFF, 0, -1, -1, -1, 16'd0);
        applyStimulus(8'h00, 0, -1, -1, -1, 16'd0);
        idle(3);
        checkOutput("t5_count", {29'd0, bus.fifo_count}, 32'd2);
        popCheck("t5_ff", 8'hFF);
        popCheck("t5_00", 8'h00);
        idle(3);
        applyStimulus(8'hC3, 0, -1, -1, 5, 16'd16);
        idle(3);
        checkOutput("t5_count_div", {29'd0, bus.fifo_count}, 32'd1);
        popCheck("t5_c3", 8'hC3);
        checkOutput("t5_ferr", {31'd0, bus.frame_err}, 32'd0);
        clk_div = 16'd8;
        bitCyc  = 8;
        idle(4);

        // 6: full FIFO, pop coinciding with the stop-sample push.
        applyStimulus(8'h11, 0, -1, -1, -1, 16'd0);
        applyStimulus(8'h22, 0, -1, -1, -1, 16'd0);
        applyStimulus(8'h33, 0, -1, -1, -1, 16'd0);
        applyStimulus(8'h44, 0, -1, -1, -1, 16'd0);
        idle(2);
        checkOutput("t6_full", {29'd0, bus.fifo_count}, 32'd4);
        applyStimulus(8'h77, 0, 78, -1, -1, 16'd0);
        idle(2);
        checkOutput("t6_count",   {29'd0, bus.fifo_count}, 32'd4);
        checkOutput("t6_overrun", {31'd0, bus.overrun}, 32'd0);
        popCheck("t6_pop22", 8'h22);
        popCheck("t6_pop33", 8'h33);
        popCheck("t6_pop44", 8'h44);
        popCheck("t6_pop77", 8'h77);
        checkOutput("t6_empty", {29'd0, bus.fifo_count}, 32'd0);
        idle(4);

        // 6b: reset in the middle of a frame with data pending.
        applyStimulus(8'h5E, 0, -1, -1, -1, 16'd0);
        idle(2);
        rx = 1'b0;
        idle(20);
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_data",  {24'd0, bus.rx_data}, 32'h0);
        checkOutput("rst2_valid", {31'd0, bus.rx_valid}, 32'd0);
        checkOutput("rst2_count", {29'd0, bus.fifo_count}, 32'd0);
        checkOutput("rst2_irq",   {31'd0, bus.irq}, 32'd0);
        checkOutput("rst2_ferr",  {31'd0, bus.frame_err}, 32'd0);
        checkOutput("rst2_ovr",   {31'd0, bus.overrun}, 32'd0);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(6);
        applyStimulus(8'hB7, 0, -1, -1, -1, 16'd0);
        idle(2);
        checkOutput("rst2_count_after", {29'd0, bus.fifo_count}, 32'd1);
        popCheck("rst2_data_after", 8'hB7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
